// File: rtl/free_list.sv
// Circular FIFO of free physical register tags feeding rename; retire returns T_old.
// Optional branch-recovery head checkpoint enabled by defining FREE_LIST_CKPT_EN.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module free_list #(
  parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
  parameter int ARCH_REG_SZ = 32,
  parameter int FL_DEPTH    = PHYS_REG_SZ - ARCH_REG_SZ,
  localparam int TW = $clog2(PHYS_REG_SZ),
  localparam int IW = $clog2(FL_DEPTH),
  localparam int PW = IW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc_req,
  output logic [TW-1:0] alloc_tag,
  output logic          alloc_valid,
  input  logic          free_req,
  input  logic [TW-1:0] free_tag,
  output logic [PW-1:0] free_count,
`ifdef FREE_LIST_CKPT_EN
  input  logic          ckpt_save,
  input  logic          ckpt_restore,
`endif
  output logic          overflow_err
);

  logic [TW-1:0] entry [FL_DEPTH];
  logic [PW-1:0] head, tail, head_nxt, tail_nxt;
  logic          empty, full, alloc_ok, free_ok, restore;

  // Pointer advance with explicit index wrap so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[IW-1:0] == IW'(FL_DEPTH - 1))
      ptr_inc = {~p[IW], {IW{1'b0}}};
    else
      ptr_inc = {p[IW], p[IW-1:0] + IW'(1)};
  endfunction

`ifdef FREE_LIST_CKPT_EN
  logic [PW-1:0] ckpt;
  assign restore = ckpt_restore;
`else
  assign restore = 1'b0;
`endif

  assign empty       = (head == tail);
  assign full        = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign alloc_valid = !empty;
  assign alloc_tag   = entry[head[IW-1:0]];

  // A restore rewinds head, so any allocation in the same cycle is void.
  assign alloc_ok = alloc_req && !empty && !restore;
  assign free_ok  = free_req && (!full || alloc_ok);

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
`ifdef FREE_LIST_CKPT_EN
    if (restore)
      head_nxt = ckpt;
    else if (alloc_ok)
      head_nxt = ptr_inc(head);
`else
    if (alloc_ok)
      head_nxt = ptr_inc(head);
`endif
    if (free_ok)
      tail_nxt = ptr_inc(tail);
  end

  always_comb begin
    free_count = '0;
    if (head[IW] == tail[IW])
      free_count = PW'(tail[IW-1:0]) - PW'(head[IW-1:0]);
    else
      free_count = PW'(FL_DEPTH) + PW'(tail[IW-1:0]) - PW'(head[IW-1:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entry[i] <= TW'(ARCH_REG_SZ + i);
      head         <= '0;
      tail         <= {1'b1, {IW{1'b0}}};
      overflow_err <= 1'b0;
    end else begin
      if (free_ok)
        entry[tail[IW-1:0]] <= free_tag;
      head         <= head_nxt;
      tail         <= tail_nxt;
      overflow_err <= free_req && !free_ok;
    end
  end

`ifdef FREE_LIST_CKPT_EN
  always_ff @(posedge clock) begin
    if (reset)
      ckpt <= '0;
    else if (ckpt_save && !ckpt_restore)
      ckpt <= head_nxt;
  end
`endif

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register tags for the R10K rename path.
- Sits directly upstream of map_table. Each dispatched instruction with a destination pops one tag; that tag becomes T written into map_table.
- Retire pushes back T_old, the previous mapping, for reuse.
- Reports the tag at the head combinationally, plus an empty flag and an occupancy count for dispatch stall logic.

Parameters:
PHYS_REG_SZ, `PHYS_REG_SZ, number of physical registers (default 64)
ARCH_REG_SZ, 32, number of architectural registers (always mapped, never free at reset)
FL_DEPTH, PHYS_REG_SZ-ARCH_REG_SZ, capacity of the list (32)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; reinitialises the list
alloc_req  in  1  dispatch requests one tag this cycle
alloc_tag  out  $clog2(PHYS_REG_SZ)  tag at head (valid when alloc_valid)
alloc_valid  out  1  list non-empty; alloc_req is honoured only when 1
free_req  in  1  retire returns one tag this cycle
free_tag  in  $clog2(PHYS_REG_SZ)  tag being returned (T_old)
free_count  out  $clog2(FL_DEPTH)+1  number of free tags held
overflow_err  out  1  registered one-cycle pulse: a free was dropped

Behaviour:
- Storage: FL_DEPTH entries. Head and tail pointers are $clog2(FL_DEPTH)+1 bits wide; the MSB is the wrap bit.
- Empty: head==tail. Full: index bits equal and wrap bits differ.
- free_count = tail - head, modulo 2*FL_DEPTH.

Reset (synchronous, dominates all other inputs, including mid-operation):
- entry[i] = ARCH_REG_SZ + i.
- head = 0; tail = FL_DEPTH (wrap bit set), so the list is full.
- free_count = FL_DEPTH; overflow_err = 0.
- alloc_tag = ARCH_REG_SZ; alloc_valid = 1.

Allocate:
- alloc_tag = entry[head index], combinational, same cycle. alloc_valid = !empty.
- alloc_req && alloc_valid: head increments at posedge. The next tag is visible the following cycle (zero-latency read, one-cycle advance).
- alloc_req && empty: ignored, no state change. The requester must check alloc_valid.

Free:
- free_req is accepted when !full, OR when an allocate succeeds in the same cycle.
- Accepted: entry[tail index] <= free_tag; tail increments.
- free_req rejected (full with no allocate): tag dropped; overflow_err = 1 for exactly the next cycle.

Simultaneous alloc and free:
- Non-empty list: both occur; free_count unchanged.
- Empty list: alloc fails (no bypass), free succeeds; count goes to 1 next cycle. The freed tag is not visible on alloc_tag until the next cycle.

Other rules:
- Wrap-around: index wraps FL_DEPTH-1 -> 0 and the wrap bit toggles. No bubbles.
- Content is never checked: duplicate or architectural tags on free_tag are stored as given.

Optional Feature:
Macro: FREE_LIST_CKPT_EN
- With the macro, two extra inputs are added: ckpt_save (1) and ckpt_restore (1), used for branch recovery.
- ckpt_save: a single checkpoint register captures the head value produced by this cycle's allocation (next-head).
- ckpt_restore:
  - head <= checkpoint; any alloc_req in the same cycle is ignored.
  - free_req in the same cycle is still processed normally.
  - restore has priority over a simultaneous save.
  - free_count reflects the restored head the next cycle.
- The checkpoint resets to 0.
- Without the macro: the ports do not exist and head changes only via allocate and reset.

Test Plan:
- Reset, then 4 cycles of alloc_req=1 -> alloc_tag 32,33,34,35 on successive cycles; free_count 32->28.
- 32 consecutive allocs -> alloc_valid=0, free_count=0; a 33rd alloc_req leaves the state unchanged.
- From empty: free_req with tag 5, then tag 7 -> alloc_tag=5 the next cycle, then 7 after one alloc; free_count 1, 2, 1.
- Full list (after reset): free_req tag 9 alone -> dropped, overflow_err high one cycle, free_count stays 32. Same cycle plus alloc_req -> both succeed, count stays 32, tag 9 stored at the tail.
- Alloc 30, free 30, alloc 5 -> pointers wrap past index 31; alloc_tag order matches free order; free_count consistent throughout.
- FREE_LIST_CKPT_EN: alloc 2, ckpt_save, alloc 3, ckpt_restore with free_req tag 40 -> alloc_tag=34, free_count=31.
